// File: rtl/nv_ram_rws_128x32_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : nv_ram_rws_128x32_fifo_ctrl
// Brief  : Valid/ready FIFO controller for a 128x32 synchronous-read RAM,
//          with a 2-entry output buffer that hides the RAM read latency.
// Rev    : 1.0  initial release
// ============================================================================
module nv_ram_rws_128x32_fifo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [31:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [31:0] rd_pd,
    output logic [7:0]  fifo_cnt,
    output logic [6:0]  ram_wa,
    output logic        ram_we,
    output logic [31:0] ram_di,
    output logic [6:0]  ram_ra,
    output logic        ram_re,
    input  logic [31:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd_in,
    output logic [31:0] pwrbus_ram_pd
);

    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam logic [7:0] FULL_CNT = 8'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [7:0]    r_ram_cnt;
    logic          r_inflight;
    logic [1:0]    r_ob_cnt;
    logic [DW-1:0] r_ob0;
    logic [DW-1:0] r_ob1;

    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic [2:0]    w_ob_occ;
    logic [1:0]    w_ob_base;
    logic [DW-1:0] w_ob0_next;
    logic [DW-1:0] w_ob1_next;

    // Handshakes
    assign wr_prdy = !rst && (r_ram_cnt != FULL_CNT);
    assign w_push  = wr_pvld && wr_prdy;
    assign rd_pvld = !rst && (r_ob_cnt != 2'd0);
    assign rd_pd   = r_ob0;
    assign w_pop   = rd_pvld && rd_prdy;

    // Output-buffer occupancy after this cycle's return and pop; a new read
    // may only be issued if that leaves room for its data next cycle.
    assign w_ob_occ  = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_ob_base = r_ob_cnt - {1'b0, w_pop};
    assign w_issue   = !rst && (r_ram_cnt != 8'd0) && (w_ob_occ < 3'd2);

    // RAM ports
    assign ram_we = w_push;
    assign ram_wa = r_wr_ptr;
    assign ram_di = wr_pd;
    assign ram_re = w_issue;
    assign ram_ra = r_rd_ptr;

    assign pwrbus_ram_pd = pwrbus_ram_pd_in;

    assign fifo_cnt = rst ? 8'd0
                          : (r_ram_cnt + {7'd0, r_inflight} + {6'd0, r_ob_cnt});

    // Shift on pop, then land returning data in the first free slot.
    always_comb begin
        w_ob0_next = r_ob0;
        w_ob1_next = r_ob1;
        if (w_pop) begin
            w_ob0_next = r_ob1;
        end
        if (r_inflight) begin
            if (w_ob_base == 2'd0) begin
                w_ob0_next = ram_dout;
            end else begin
                w_ob1_next = ram_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= 8'd0;
            r_inflight <= 1'b0;
            r_ob_cnt   <= 2'd0;
            r_ob0      <= '0;
            r_ob1      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_cnt  <= r_ram_cnt + {7'd0, w_push} - {7'd0, w_issue};
            r_inflight <= w_issue;
            r_ob_cnt   <= w_ob_occ[1:0];
            r_ob0      <= w_ob0_next;
            r_ob1      <= w_ob1_next;
        end
    end

`ifndef SYNTHESIS
    a_ob_no_overflow: assert property (@(posedge clk) disable iff (rst) w_ob_occ <= 3'd2);
`endif

endmodule
`default_nettype wire

// File: tb/tb_nv_ram_rws_128x32_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_nv_ram_rws_128x32_fifo_ctrl
// Brief  : Directed self-checking bench with a behavioural 128x32 RAM model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_nv_ram_rws_128x32_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [31:0] wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [31:0] rd_pd;
    logic [7:0]  fifo_cnt;
    logic [6:0]  ram_wa;
    logic        ram_we;
    logic [31:0] ram_di;
    logic [6:0]  ram_ra;
    logic        ram_re;
    logic [31:0] ram_dout;
    logic [31:0] pwrbus_ram_pd_in;
    logic [31:0] pwrbus_ram_pd;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];
    logic [31:0] mem [0:127];

    always #5 clk = ~clk;

    nv_ram_rws_128x32_fifo_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .wr_pvld          (wr_pvld),
        .wr_prdy          (wr_prdy),
        .wr_pd            (wr_pd),
        .rd_pvld          (rd_pvld),
        .rd_prdy          (rd_prdy),
        .rd_pd            (rd_pd),
        .fifo_cnt         (fifo_cnt),
        .ram_wa           (ram_wa),
        .ram_we           (ram_we),
        .ram_di           (ram_di),
        .ram_ra           (ram_ra),
        .ram_re           (ram_re),
        .ram_dout         (ram_dout),
        .pwrbus_ram_pd_in (pwrbus_ram_pd_in),
        .pwrbus_ram_pd    (pwrbus_ram_pd)
    );

    // Two-port RAM with one-cycle synchronous read
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; wr_pvld = 1'b1; wr_pd = 32'h5; rd_prdy = 1'b1;
        pwrbus_ram_pd_in = 32'hA5A5_0F0F;
        #1;
        checks++;
        if ({wr_prdy, rd_pvld, ram_we, ram_re} !== 4'b0000 || fifo_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got prdy=%b pvld=%b we=%b re=%b cnt=%0d, want all 0",
                     wr_prdy, rd_pvld, ram_we, ram_re, fifo_cnt);
        end
        checks++;
        if (pwrbus_ram_pd !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL pwrbus: got %h want a5a50f0f", pwrbus_ram_pd);
        end
        @(negedge clk);
        rst = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0;
        #1;
        checks++;
        if (wr_prdy !== 1'b1 || rd_pvld !== 1'b0 || fifo_cnt !== 8'd0) begin
            errors++;
            $display("FAIL idle_state: got prdy=%b pvld=%b cnt=%0d, want 1 0 0", wr_prdy, rd_pvld, fifo_cnt);
        end
        checks++;
        if (ram_we !== 1'b0 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL idle_ram: got we=%b re=%b, want 0 0", ram_we, ram_re);
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        wr_pvld = 1'b1; wr_pd = 32'hDEAD_BEEF; rd_prdy = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_wa !== 7'd0 || ram_di !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write: got we=%b wa=%0d di=%h, want 1 0 deadbeef", ram_we, ram_wa, ram_di);
        end
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        checks++;
        if (ram_re !== 1'b1 || ram_ra !== 7'd0 || rd_pvld !== 1'b0 || fifo_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_issue: got re=%b ra=%0d pvld=%b cnt=%0d, want 1 0 0 1", ram_re, ram_ra, rd_pvld, fifo_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rd_pvld !== 1'b0 || fifo_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_inflight: got pvld=%b cnt=%0d, want 0 1", rd_pvld, fifo_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rd_pvld !== 1'b1 || rd_pd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_pop: got pvld=%b pd=%h, want 1 deadbeef", rd_pvld, rd_pd);
        end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++;
        if (rd_pvld !== 1'b0 || fifo_cnt !== 8'd0) begin
            errors++;
            $display("FAIL single_empty: got pvld=%b cnt=%0d, want 0 0", rd_pvld, fifo_cnt);
        end
    endtask

    task automatic test_full;
        int acc = 0;
        int exp = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            wr_pvld = 1'b1; wr_pd = acc; rd_prdy = 1'b0;
            #1;
            if (wr_pvld && wr_prdy) acc++;
        end
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        checks++;
        if (acc != 130) begin
            errors++;
            $display("FAIL full_accepts: got %0d want 130", acc);
        end
        checks++;
        if (wr_prdy !== 1'b0 || fifo_cnt !== 8'd130 || rd_pvld !== 1'b1 || rd_pd !== 32'd0) begin
            errors++;
            $display("FAIL full_state: got prdy=%b cnt=%0d pvld=%b pd=%0d, want 0 130 1 0", wr_prdy, fifo_cnt, rd_pvld, rd_pd);
        end
        for (int c = 0; c < 400 && exp < 130; c++) begin
            @(negedge clk);
            rd_prdy = 1'b1;
            #1;
            if (c == 0) begin
                checks++;
                if (ram_re !== 1'b1 || wr_prdy !== 1'b0) begin
                    errors++;
                    $display("FAIL full_release: got re=%b prdy=%b, want 1 0", ram_re, wr_prdy);
                end
            end
            if (c == 1) begin
                checks++;
                if (wr_prdy !== 1'b1) begin
                    errors++;
                    $display("FAIL full_reready: got prdy=%b want 1", wr_prdy);
                end
            end
            if (rd_pvld) begin
                checks++;
                if (rd_pd !== 32'(exp)) begin
                    errors++;
                    $display("FAIL full_order: got %0d want %0d", rd_pd, exp);
                end
                exp++;
            end
        end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++;
        if (exp != 130 || fifo_cnt !== 8'd0) begin
            errors++;
            $display("FAIL full_drain: got pops=%0d cnt=%0d, want 130 0", exp, fifo_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int nxt = 0;
        int exp = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            wr_pvld = 1'b1; wr_pd = 32'h1000 + nxt; rd_prdy = 1'b1;
            #1;
            if (c >= 3) begin
                checks++;
                if (rd_pvld !== 1'b1 || (fifo_cnt !== 8'd2 && fifo_cnt !== 8'd3)) begin
                    errors++;
                    $display("FAIL stream_steady: cycle %0d got pvld=%b cnt=%0d, want 1 and 2..3", c, rd_pvld, fifo_cnt);
                end
            end
            if (wr_prdy) nxt++;
            if (rd_pvld) begin
                checks++;
                if (rd_pd !== 32'h1000 + exp) begin
                    errors++;
                    $display("FAIL stream_order: got %h want %h", rd_pd, 32'h1000 + exp);
                end
                exp++;
            end
        end
        for (int c = 0; c < 20 && exp < nxt; c++) begin
            @(negedge clk);
            wr_pvld = 1'b0;
            #1;
            if (rd_pvld) begin
                checks++;
                if (rd_pd !== 32'h1000 + exp) begin
                    errors++;
                    $display("FAIL stream_order: got %h want %h", rd_pd, 32'h1000 + exp);
                end
                exp++;
            end
        end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++;
        if (nxt != 1000 || exp != 1000 || fifo_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stream_total: got push=%0d pop=%0d cnt=%0d, want 1000 1000 0", nxt, exp, fifo_cnt);
        end
    endtask

    task automatic test_random;
        logic [31:0] e;
        q.delete();
        for (int c = 0; c < 22000; c++) begin
            @(negedge clk);
            wr_pvld = 1'($urandom_range(0, 1));
            wr_pd   = $urandom;
            rd_prdy = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (fifo_cnt !== 8'(q.size())) begin
                errors++;
                $display("FAIL rand_count: cycle %0d got %0d want %0d", c, fifo_cnt, q.size());
            end
            if (rd_pvld && rd_prdy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_underflow: got pop of %h want no pop", rd_pd);
                end else begin
                    e = q.pop_front();
                    if (rd_pd !== e) begin
                        errors++;
                        $display("FAIL rand_order: got %h want %h", rd_pd, e);
                    end
                end
            end
            if (wr_pvld && wr_prdy) q.push_back(wr_pd);
        end
        for (int c = 0; c < 300 && q.size() != 0; c++) begin
            @(negedge clk);
            wr_pvld = 1'b0; rd_prdy = 1'b1;
            #1;
            if (rd_pvld) begin
                e = q.pop_front();
                checks++;
                if (rd_pd !== e) begin
                    errors++;
                    $display("FAIL rand_drain: got %h want %h", rd_pd, e);
                end
            end
        end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++;
        if (q.size() != 0 || fifo_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rand_empty: got left=%0d cnt=%0d, want 0 0", q.size(), fifo_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int acc = 0;
        bit got = 1'b0;
        for (int c = 0; c < 60 && acc < 50; c++) begin
            @(negedge clk);
            wr_pvld = 1'b1; wr_pd = 100 + acc; rd_prdy = 1'b0;
            #1;
            if (wr_prdy) acc++;
        end
        @(negedge clk);
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        #1;
        checks++;
        if (rd_pvld !== 1'b1 || rd_pd !== 32'd100 || ram_re !== 1'b1 || fifo_cnt !== 8'd50) begin
            errors++;
            $display("FAIL mid_setup: got pvld=%b pd=%0d re=%b cnt=%0d, want 1 100 1 50", rd_pvld, rd_pd, ram_re, fifo_cnt);
        end
        @(negedge clk);
        rst = 1'b1; rd_prdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (fifo_cnt !== 8'd0 || rd_pvld !== 1'b0 || wr_prdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%0d pvld=%b prdy=%b, want 0 0 1", fifo_cnt, rd_pvld, wr_prdy);
        end
        @(negedge clk);
        wr_pvld = 1'b1; wr_pd = 32'h1; rd_prdy = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            wr_pvld = 1'b0;
            #1;
            if (rd_pvld) begin
                got = 1'b1;
                checks++;
                if (rd_pd !== 32'h1) begin
                    errors++;
                    $display("FAIL mid_first_pop: got %h want 00000001", rd_pd);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL mid_timeout: got no pop want pop of 00000001");
        end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++;
        if (fifo_cnt !== 8'd0 || rd_pvld !== 1'b0) begin
            errors++;
            $display("FAIL mid_empty: got cnt=%0d pvld=%b, want 0 0", fifo_cnt, rd_pvld);
        end
    endtask

    initial begin
        rst = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
        pwrbus_ram_pd_in = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
